// File: rtl/mmio_pkg.sv
// Shared constants and types for the CPU MMIO bridge: window offsets, FSM states, STATUS layout.
package mmio_pkg;

    localparam logic [7:0] OFS_CHAR_TX = 8'h00;
    localparam logic [7:0] OFS_STATUS  = 8'h04;
    localparam logic [7:0] OFS_REG0    = 8'h08;

    localparam int STATUS_FAULT_BIT = 31;
    localparam int STATUS_FULL_BIT  = 30;
    localparam int STATUS_EMPTY_BIT = 29;

    typedef enum logic [1:0] {
        IDLE,
        ROM_WAIT,
        STALL,
        ACK
    } mmio_state_t;

    typedef enum logic [2:0] {
        TGT_ROM,
        TGT_CHAR,
        TGT_STATUS,
        TGT_REG,
        TGT_UNMAPPED
    } mmio_target_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push ignored when full, pop ignored when empty, flags sampled at cycle start.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mmio_bridge.sv
// picorv32 native-bus slave: boot ROM, byte-writable control registers, char TX FIFO, STATUS.
// state    | meaning
// IDLE     | waiting for mem_valid; decodes and performs single-cycle accesses
// ROM_WAIT | counting down ROM latency, captures rom_q_i on terminal count
// STALL    | char write pending while FIFO full, retried every cycle
// ACK      | mem_ready pulse, back to IDLE
module cpu_mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          NUM_REGS        = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int          ROM_WORDS       = 1024,
    parameter int          ROM_LATENCY     = 1,
    parameter int          CHAR_FIFO_DEPTH = 16
) (
    input  logic                          clk_25mhz,
    input  logic                          reset_n,
    input  logic                          mem_valid,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_wdata,
    input  logic [3:0]                    mem_wstrb,
    output logic                          mem_ready,
    output logic [31:0]                   mem_rdata,
    output logic [$clog2(ROM_WORDS)-1:0]  rom_addr_o,
    input  logic [31:0]                   rom_q_i,
    output logic [NUM_REGS*32-1:0]        regs_o,
    output logic [7:0]                    char_data_o,
    output logic                          char_valid_o,
    input  logic                          char_ready_i,
    output logic                          fault_o
);
    localparam int          RA_W      = $clog2(ROM_WORDS);
    localparam int          CW        = $clog2(CHAR_FIFO_DEPTH) + 1;
    localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) << 2;

    mmio_state_t        state, state_next;
    mmio_target_t       target;
    logic [RA_W-1:0]    rom_addr_q;
    logic [7:0]         char_q;
    logic               write_q;
    logic [2:0]         lat_cnt;
    logic [NUM_REGS*32-1:0] regs;
    logic               fault;
    logic               is_write;
    logic [5:0]         reg_slot;
    logic [5:0]         reg_idx;
    logic [31:0]        reg_word;
    logic [31:0]        status_word;

    logic               latch_req, lat_load, lat_dec, load_rdata;
    logic               reg_we, fault_set, fault_clr;
    logic [31:0]        rdata_next;
    logic               fifo_push, fifo_full, fifo_empty;
    logic [7:0]         push_data;
    logic [CW-1:0]      fifo_count;

    assign is_write = |mem_wstrb;
    assign reg_slot = mem_addr[7:2];
    assign reg_idx  = reg_slot - OFS_REG0[7:2];

    always_comb begin
        target = TGT_UNMAPPED;
        if ({1'b0, mem_addr} < ROM_BYTES) begin
            target = TGT_ROM;
        end else if (mem_addr[31:8] == BASE_ADDR[31:8]) begin
            if (mem_addr[7:0] == OFS_CHAR_TX) begin
                target = TGT_CHAR;
            end else if (mem_addr[7:0] == OFS_STATUS) begin
                target = TGT_STATUS;
            end else if (mem_addr[1:0] == 2'b00 && reg_slot >= OFS_REG0[7:2]
                         && reg_slot < OFS_REG0[7:2] + 6'(NUM_REGS)) begin
                target = TGT_REG;
            end
        end
    end

    always_comb begin
        reg_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_idx == 6'(i)) begin
                reg_word = regs[32*i +: 32];
            end
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_FAULT_BIT] = fault;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[15:0]             = 16'(fifo_count);
    end

    // ROM sees the live bus address in IDLE so its latency starts at the accept cycle
    assign rom_addr_o = (state == IDLE) ? mem_addr[RA_W+1:2] : rom_addr_q;

    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_ready  = 1'b0;
        latch_req  = 1'b0;
        lat_load   = 1'b0;
        lat_dec    = 1'b0;
        load_rdata = 1'b0;
        rdata_next = '0;
        reg_we     = 1'b0;
        fault_set  = 1'b0;
        fault_clr  = 1'b0;
        fifo_push  = 1'b0;
        push_data  = mem_wdata[7:0];
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    latch_req = 1'b1;
                    case (target)
                        TGT_ROM: begin
                            lat_load   = 1'b1;
                            state_next = ROM_WAIT;
                        end
                        TGT_CHAR: begin
                            if (is_write && mem_wstrb[0] && fifo_full) begin
                                state_next = STALL;
                            end else begin
                                fifo_push  = is_write && mem_wstrb[0];
                                load_rdata = 1'b1;
                                state_next = ACK;
                            end
                        end
                        TGT_STATUS: begin
                            load_rdata = 1'b1;
                            rdata_next = is_write ? 32'h0 : status_word;
                            fault_clr  = is_write && mem_wdata[31];
                            state_next = ACK;
                        end
                        TGT_REG: begin
                            load_rdata = 1'b1;
                            rdata_next = is_write ? 32'h0 : reg_word;
                            reg_we     = is_write;
                            state_next = ACK;
                        end
                        default: begin
                            load_rdata = 1'b1;
                            fault_set  = 1'b1;
                            state_next = ACK;
                        end
                    endcase
                end
            end
            ROM_WAIT: begin
                if (lat_cnt == '0) begin
                    load_rdata = 1'b1;
                    rdata_next = write_q ? 32'h0 : rom_q_i;
                    fault_set  = write_q;
                    state_next = ACK;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            STALL: begin
                push_data = char_q;
                if (!fifo_full) begin
                    fifo_push  = 1'b1;
                    load_rdata = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                mem_ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            char_q     <= '0;
            write_q    <= 1'b0;
            lat_cnt    <= '0;
            mem_rdata  <= '0;
            fault      <= 1'b0;
            regs       <= '0;
        end else begin
            if (latch_req) begin
                rom_addr_q <= mem_addr[RA_W+1:2];
                char_q     <= mem_wdata[7:0];
                write_q    <= is_write;
            end
            if (lat_load) begin
                lat_cnt <= 3'(ROM_LATENCY - 1);
            end else if (lat_dec) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (load_rdata) begin
                mem_rdata <= rdata_next;
            end
            // a new fault wins over a simultaneous clear
            if (fault_set) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
            if (reg_we) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (reg_idx == 6'(i) && mem_wstrb[b]) begin
                            regs[32*i + 8*b +: 8] <= mem_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CHAR_FIFO_DEPTH)
    ) u_char_fifo (
        .clk      (clk_25mhz),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .data_in  (push_data),
        .pop      (char_ready_i),
        .data_out (char_data_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign regs_o       = regs;
    assign char_valid_o = !fifo_empty;
    assign fault_o      = fault;

endmodule

// File: tb/tb_cpu_mmio_bridge.sv
// Self-checking bench for cpu_mmio_bridge against a queue/array model of the memory map.
module tb_cpu_mmio_bridge;
    localparam int          NUM_REGS  = 8;
    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int          ROM_WORDS = 1024;
    localparam int          DEPTH     = 16;

    logic                    clk_25mhz = 1'b0;
    logic                    reset_n   = 1'b0;
    logic                    mem_valid = 1'b0;
    logic [31:0]             mem_addr  = '0;
    logic [31:0]             mem_wdata = '0;
    logic [3:0]              mem_wstrb = '0;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;
    logic [9:0]              rom_addr_o;
    logic [31:0]             rom_q_i = '0;
    logic [NUM_REGS*32-1:0]  regs_o;
    logic [7:0]              char_data_o;
    logic                    char_valid_o;
    logic                    char_ready_i = 1'b0;
    logic                    fault_o;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rom_mem [ROM_WORDS];
    logic [31:0] regs_m  [NUM_REGS];
    logic [7:0]  fifo_q  [$];
    logic        fault_m;

    cpu_mmio_bridge #(
        .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .ROM_WORDS(ROM_WORDS),
        .ROM_LATENCY(1), .CHAR_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_25mhz(clk_25mhz), .reset_n(reset_n), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rom_addr_o(rom_addr_o),
        .rom_q_i(rom_q_i), .regs_o(regs_o), .char_data_o(char_data_o),
        .char_valid_o(char_valid_o), .char_ready_i(char_ready_i), .fault_o(fault_o)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // synchronous ROM, one cycle of latency
    always @(posedge clk_25mhz) rom_q_i <= rom_mem[rom_addr_o];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [NUM_REGS*32-1:0] regs_flat();
        logic [NUM_REGS*32-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = regs_m[i];
        return v;
    endfunction

    function automatic logic [31:0] status_exp();
        int n;
        n = fifo_q.size();
        return {fault_m, (n == DEPTH), (n == 0), 13'b0, 16'(n)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) regs_m[i] = '0;
        fifo_q.delete();
        fault_m = 1'b0;
    endtask

    task automatic wait_ready(inout int lat, output logic [31:0] rd);
        rd = 'x;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_25mhz);
            if (mem_ready === 1'b1) begin
                rd = mem_rdata;
                return;
            end
            @(posedge clk_25mhz);
            lat++;
        end
        lat = -1;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
        @(posedge clk_25mhz); #1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        @(posedge clk_25mhz);
        lat = 1;
        wait_ready(lat, rd);
        mem_valid = 1'b0; mem_wstrb = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_valid = 1'b0; char_ready_i = 1'b0;
        repeat (3) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        compared++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_bus: ready=%b rdata=%h expected 0/0", mem_ready, mem_rdata);
        end
        compared++;
        if (regs_o !== '0 || char_valid_o !== 1'b0 || fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: regs=%h cv=%b fault=%b expected all 0", regs_o, char_valid_o, fault_o);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rom_read();
        logic [31:0] rd; int lat;
        access(32'h0, 32'h0, 4'h0, rd, lat);
        compared++;
        if (lat !== 2 || rd !== 32'h0000_0513) begin
            mismatched++;
            $display("FAIL rom_word0: lat=%0d rdata=%h expected 2 / 00000513", lat, rd);
        end
    endtask

    task automatic test_reg_write();
        logic [31:0] rd; int lat;
        access(BASE + 32'h0C, 32'hAABB_CCDD, 4'b0101, rd, lat);
        regs_m[1] = merge(regs_m[1], 32'hAABB_CCDD, 4'b0101);
        compared++;
        if (lat !== 1 || regs_o[63:32] !== 32'h00BB_00DD || rd !== 32'h0) begin
            mismatched++;
            $display("FAIL reg1_bytes: lat=%0d reg1=%h rdata=%h expected 1 / 00bb00dd / 0", lat, regs_o[63:32], rd);
        end
    endtask

    task automatic test_fault();
        logic [31:0] rd; int lat;
        access(32'h2000, 32'h0, 4'h0, rd, lat);
        fault_m = 1'b1;
        compared++;
        if (lat !== 1 || rd !== 32'h0 || fault_o !== 1'b1) begin
            mismatched++;
            $display("FAIL unmapped_read: lat=%0d rdata=%h fault=%b expected 1/0/1", lat, rd, fault_o);
        end
        access(BASE + 32'h04, 32'h0, 4'h0, rd, lat);
        compared++;
        if (rd !== status_exp()) begin
            mismatched++;
            $display("FAIL status_fault: got %h expected %h", rd, status_exp());
        end
        access(BASE + 32'h04, 32'h8000_0000, 4'hF, rd, lat);
        fault_m = 1'b0;
        compared++;
        if (fault_o !== 1'b0 || lat !== 1) begin
            mismatched++;
            $display("FAIL fault_clear: fault=%b lat=%0d expected 0/1", fault_o, lat);
        end
    endtask

    task automatic test_char_full();
        logic [31:0] rd; int lat; logic [7:0] c; bit early;
        for (int k = 0; k < DEPTH; k++) begin
            c = 8'($urandom);
            access(BASE, {24'($urandom), c}, 4'b0001, rd, lat);
            fifo_q.push_back(c);
            compared++;
            if (lat !== 1) begin
                mismatched++;
                $display("FAIL char_push_lat: push %0d lat=%0d expected 1", k, lat);
            end
        end
        compared++;
        if (char_valid_o !== 1'b1 || char_data_o !== fifo_q[0]) begin
            mismatched++;
            $display("FAIL char_head: valid=%b data=%h expected 1/%h", char_valid_o, char_data_o, fifo_q[0]);
        end
        c = 8'($urandom);
        @(posedge clk_25mhz); #1;
        mem_valid = 1'b1; mem_addr = BASE; mem_wdata = {24'h0, c}; mem_wstrb = 4'b0001;
        early = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_25mhz);
            if (mem_ready !== 1'b0) early = 1;
        end
        compared++;
        if (early) begin
            mismatched++;
            $display("FAIL char_stall: ready seen=1 while full, expected 0");
        end
        @(posedge clk_25mhz); #1;
        char_ready_i = 1'b1;
        @(posedge clk_25mhz); #1;
        char_ready_i = 1'b0;
        void'(fifo_q.pop_front());
        lat = 1;
        wait_ready(lat, rd);
        mem_valid = 1'b0; mem_wstrb = '0;
        fifo_q.push_back(c);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL char_unstall_lat: lat=%0d expected 2", lat);
        end
        access(BASE + 32'h04, 32'h0, 4'h0, rd, lat);
        compared++;
        if (rd !== status_exp() || rd[15:0] !== 16'd16) begin
            mismatched++;
            $display("FAIL status_full: got %h expected %h", rd, status_exp());
        end
    endtask

    task automatic test_fifo_drain();
        @(posedge clk_25mhz); #1;
        char_ready_i = 1'b1;
        for (int k = 0; k < DEPTH + 3; k++) begin
            @(negedge clk_25mhz);
            compared++;
            if (char_valid_o !== (fifo_q.size() > 0) ||
                (fifo_q.size() > 0 && char_data_o !== fifo_q[0])) begin
                mismatched++;
                $display("FAIL drain_%0d: valid=%b data=%h expected %b/%h", k, char_valid_o,
                         char_data_o, (fifo_q.size() > 0), (fifo_q.size() > 0) ? fifo_q[0] : 8'h0);
            end
            @(posedge clk_25mhz);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        #1 char_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; logic [31:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        access(BASE + 32'h08, d0, 4'hF, rd, lat);
        access(BASE + 32'h0C, d1, 4'hF, rd, lat);
        regs_m[0] = d0; regs_m[1] = d1;
        @(posedge clk_25mhz); #1;
        mem_valid = 1'b1; mem_addr = BASE + 32'h08; mem_wstrb = 4'h0;
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        compared++;
        if (mem_ready !== 1'b1 || mem_rdata !== regs_m[0]) begin
            mismatched++;
            $display("FAIL b2b_first: ready=%b rdata=%h expected 1/%h", mem_ready, mem_rdata, regs_m[0]);
        end
        mem_addr = BASE + 32'h0C;
        @(negedge clk_25mhz);
        compared++;
        if (mem_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_gap: ready=%b expected 0", mem_ready);
        end
        @(negedge clk_25mhz);
        compared++;
        if (mem_ready !== 1'b1 || mem_rdata !== regs_m[1]) begin
            mismatched++;
            $display("FAIL b2b_second: ready=%b rdata=%h expected 1/%h", mem_ready, mem_rdata, regs_m[1]);
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp_rd; logic [3:0] s; int lat, exp_lat, i, kind;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 7);
            i = $urandom_range(0, NUM_REGS - 1);
            d = $urandom; s = 4'h0; exp_rd = 32'h0; exp_lat = 1;
            a = BASE + 32'h08 + 32'(4 * i);
            case (kind)
                0: begin s = 4'($urandom_range(1, 15)); regs_m[i] = merge(regs_m[i], d, s); end
                1: exp_rd = regs_m[i];
                2: begin a = BASE + 32'h04; exp_rd = status_exp(); end
                3: begin a = BASE + 32'h04; s = 4'hF; if (d[31]) fault_m = 1'b0; end
                4: begin
                    i = $urandom_range(0, ROM_WORDS - 1);
                    a = 32'(4 * i); exp_rd = rom_mem[i]; exp_lat = 2;
                end
                5: begin
                    a = 32'(4 * $urandom_range(0, ROM_WORDS - 1));
                    s = 4'($urandom_range(1, 15)); exp_lat = 2; fault_m = 1'b1;
                end
                6: begin
                    a = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * $urandom_range(10, 63))
                                                    : 32'h2000 + 32'(4 * $urandom_range(0, 4000));
                    s = 4'($urandom_range(0, 15)); fault_m = 1'b1;
                end
                default: begin
                    a = BASE;
                    if (fifo_q.size() < DEPTH) begin
                        s = 4'($urandom_range(1, 15));
                        if (s[0]) fifo_q.push_back(d[7:0]);
                    end
                end
            endcase
            access(a, d, s, rd, lat);
            compared++;
            if (rd !== exp_rd || lat !== exp_lat || fault_o !== fault_m || regs_o !== regs_flat()) begin
                mismatched++;
                $display("FAIL rand_%0d kind%0d a=%h: rdata=%h lat=%0d fault=%b expected %h/%0d/%b regs_ok=%b",
                         n, kind, a, rd, lat, fault_o, exp_rd, exp_lat, fault_m, regs_o === regs_flat());
            end
        end
    endtask

    task automatic test_reset_mid_rom();
        logic [31:0] rd; int lat;
        for (int k = 0; k < 3; k++) access(BASE, 32'($urandom), 4'b0001, rd, lat);
        access(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, rd, lat);
        access(32'h2000, 32'h0, 4'h0, rd, lat);
        @(posedge clk_25mhz); #1;
        mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'h0;
        @(posedge clk_25mhz); #1;
        reset_n = 1'b0; mem_valid = 1'b0;
        @(negedge clk_25mhz);
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        compared++;
        if (mem_ready !== 1'b0 || char_valid_o !== 1'b0 || regs_o !== '0 || fault_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_rom: ready=%b cv=%b regs=%h fault=%b expected 0/0/0/0",
                     mem_ready, char_valid_o, regs_o, fault_o);
        end
        reset_n = 1'b1;
        model_reset();
        access(BASE + 32'h04, 32'h0, 4'h0, rd, lat);
        compared++;
        if (rd !== status_exp() || lat !== 1) begin
            mismatched++;
            $display("FAIL status_after_reset: got %h lat=%0d expected %h/1", rd, lat, status_exp());
        end
    endtask

    initial begin
        for (int k = 0; k < ROM_WORDS; k++) rom_mem[k] = $urandom;
        rom_mem[0] = 32'h0000_0513;
        model_reset();
        test_reset();
        test_rom_read();
        test_reg_write();
        test_fault();
        test_char_full();
        test_fifo_drain();
        test_back_to_back();
        test_random();
        test_reset_mid_rom();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
